sparam_iq_accum: RTL and testbench

SPARAM_IQ_ACCUM -- requirements
Module: sparam_iq_accum

---
 rtl/sparam_pkg.sv | 52 +++++
 rtl/sparam_nco_lut.sv | 67 ++++++
 rtl/sparam_iq_accum.sv | 158 +++++++++++++++
 tb/tb_sparam_iq_accum.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparam_pkg.sv
// Shared types, default sizes and the accumulator add for the S-parameter I/Q correlator.
// Define SPARAM_ACC_SAT_EN to make accumulator sums clamp instead of wrapping.
package sparam_pkg;

   localparam int DW_DEF = 12;
   localparam int CW_DEF = 12;
   localparam int LW_DEF = 8;
   localparam int PW_DEF = 24;
   localparam int AW_DEF = 40;
   localparam int NW_DEF = 16;

   // Additions are evaluated at this width, so accumulator widths up to ADD_W-2 are exact.
   localparam int ADD_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic                    ovf;
      logic signed [ADD_W-1:0] sum;
   } add_res_t;

   // a and b are w-bit signed values sign-extended to ADD_W; the sum is returned the same way.
   function automatic add_res_t acc_add(input logic signed [ADD_W-1:0] a,
                                        input logic signed [ADD_W-1:0] b,
                                        input int                      w);
      add_res_t                r;
      logic signed [ADD_W-1:0] s;
      logic signed [ADD_W-1:0] hi;
      logic signed [ADD_W-1:0] lo;
      s     = a + b;
      hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo    = -hi - 64'sd1;
      r.ovf = (s > hi) || (s < lo);
`ifdef SPARAM_ACC_SAT_EN
      if (s > hi)
         r.sum = hi;
      else if (s < lo)
         r.sum = lo;
      else
         r.sum = s;
`else
      r.sum = (s <<< (ADD_W - w)) >>> (ADD_W - w);
`endif
      return r;
   endfunction

endpackage

// File: rtl/sparam_nco_lut.sv
// Sine/cosine reference table indexed by the top LW phase bits, one registered cycle of latency.
// Table contents are elaborated from round((2^(CW-1)-1) * sin(2*pi*i/2^LW)).
module sparam_nco_lut
   import sparam_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int LW = LW_DEF,
   parameter int PW = PW_DEF
) (
   input  logic          clk,
   input  logic          en,
   input  logic [PW-1:0] phase,
   output logic [CW-1:0] sin_p0,
   output logic [CW-1:0] cos_p0
);

   localparam int DEPTH = 1 << LW;
   localparam int QTR   = 1 << (LW - 2);

   // Taylor series on an angle folded into [-pi, pi]; error is far below the rounding step.
   function automatic int sin_entry(input int idx, input int lw, input int cw);
      real pi;
      real x;
      real term;
      real sum;
      real amp;
      pi   = 3.14159265358979323846;
      x    = 2.0 * pi * $itor(idx) / $itor(1 << lw);
      if (x > pi)
         x = x - 2.0 * pi;
      term = x;
      sum  = x;
      for (int k = 1; k <= 20; k++) begin
         term = -term * x * x / $itor((2 * k) * (2 * k + 1));
         sum  = sum + term;
      end
      amp = $itor((1 << (cw - 1)) - 1) * sum;
      if (amp >= 0.0)
         return $rtoi(amp + 0.5);
      else
         return -$rtoi(0.5 - amp);
   endfunction

   logic signed [CW-1:0] sin_tab [DEPTH];

   for (genvar g = 0; g < DEPTH; g++) begin : g_tab
      localparam int V = sin_entry(g, LW, CW);
      assign sin_tab[g] = V[CW-1:0];
   end

   logic [LW-1:0] sin_idx;
   logic [LW-1:0] cos_idx;
   logic          unused_phase_lsb;

   assign sin_idx          = phase[PW-1 -: LW];
   assign cos_idx          = sin_idx + LW'(QTR);
   assign unused_phase_lsb = ^phase[PW-LW-1:0];

   // stage p0: reference values registered alongside the accepted sample
   always_ff @(posedge clk) begin
      if (en) begin
         sin_p0 <= sin_tab[sin_idx];
         cos_p0 <= sin_tab[cos_idx];
      end
   end

endmodule

// File: rtl/sparam_iq_accum.sv
// Correlates streamed port samples against an internal sin/cos reference and returns one I/Q pair.
// Define SPARAM_ACC_SAT_EN to saturate the accumulators; by default they wrap.
module sparam_iq_accum
   import sparam_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int CW = CW_DEF,
   parameter int LW = LW_DEF,
   parameter int PW = PW_DEF,
   parameter int AW = AW_DEF,
   parameter int NW = NW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [PW-1:0] ftw,
   input  logic [NW-1:0] n_samples,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [AW-1:0] m_i,
   output logic [AW-1:0] m_q,
   output logic          busy,
   output logic          ovf
);

   state_t state;
   state_t state_nx;

   logic [PW-1:0] ftw_r;
   logic [PW-1:0] phase;
   logic [NW-1:0] n_r;
   logic [NW-1:0] cnt;
   logic          accept;
   logic          last;
   logic          start_ok;

   logic                    vld_p0;
   logic                    vld_p1;
   logic signed [DW-1:0]    x_p0;
   logic [CW-1:0]           sin_raw_p0;
   logic [CW-1:0]           cos_raw_p0;
   logic signed [CW-1:0]    sin_p0;
   logic signed [CW-1:0]    cos_p0;
   logic signed [DW+CW-1:0] prod_i_p1;
   logic signed [DW+CW-1:0] prod_q_p1;
   logic signed [AW-1:0]    acc_i;
   logic signed [AW-1:0]    acc_q;
   logic                    ovf_r;
   add_res_t                res_i;
   add_res_t                res_q;
   logic                    unused_sum_hi;

   assign start_ok = (state == ST_IDLE) && start;
   assign s_ready  = (state == ST_ACCUM) && (cnt < n_r);
   assign accept   = s_valid && s_ready;
   assign last     = accept && (cnt == n_r - NW'(1));

   assign busy    = (state != ST_IDLE);
   assign m_valid = (state == ST_DONE);
   assign m_i     = acc_i;
   assign m_q     = acc_q;
   assign ovf     = ovf_r;

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // DRAIN ends once stage p0 is empty: the last product is absorbed on that same edge.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (start) state_nx = (n_samples == '0) ? ST_DONE : ST_ACCUM;
         ST_ACCUM: if (last) state_nx = ST_DRAIN;
         ST_DRAIN: if (!vld_p0) state_nx = ST_DONE;
         ST_DONE:  if (m_ready) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   sparam_nco_lut #(
      .CW (CW),
      .LW (LW),
      .PW (PW)
   ) u_lut (
      .clk    (clk),
      .en     (accept),
      .phase  (phase),
      .sin_p0 (sin_raw_p0),
      .cos_p0 (cos_raw_p0)
   );

   assign sin_p0 = sin_raw_p0;
   assign cos_p0 = cos_raw_p0;

   // stage p0: accepted sample captured in step with the table output
   always_ff @(posedge clk) begin
      if (accept)
         x_p0 <= s_data;
   end

   // stage p1: full-precision products
   always_ff @(posedge clk) begin
      prod_i_p1 <= x_p0 * cos_p0;
      prod_q_p1 <= x_p0 * sin_p0;
   end

   always_comb begin
      res_i = acc_add(ADD_W'(acc_i), ADD_W'(prod_i_p1), AW);
      res_q = acc_add(ADD_W'(acc_q), ADD_W'(prod_q_p1), AW);
   end

   assign unused_sum_hi = ^{res_i.sum[ADD_W-1:AW], res_q.sum[ADD_W-1:AW]};

   // accumulate stage: control, phase/count and sums
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ftw_r  <= '0;
         n_r    <= '0;
         phase  <= '0;
         cnt    <= '0;
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         acc_i  <= '0;
         acc_q  <= '0;
         ovf_r  <= 1'b0;
      end else begin
         vld_p0 <= accept;
         vld_p1 <= vld_p0;
         if (start_ok) begin
            ftw_r <= ftw;
            n_r   <= n_samples;
            phase <= '0;
            cnt   <= '0;
            acc_i <= '0;
            acc_q <= '0;
            ovf_r <= 1'b0;
         end else begin
            if (accept) begin
               phase <= phase + ftw_r;
               cnt   <= cnt + NW'(1);
            end
            if (vld_p1) begin
               acc_i <= res_i.sum[AW-1:0];
               acc_q <= res_q.sum[AW-1:0];
               if (res_i.ovf || res_q.ovf)
                  ovf_r <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sparam_iq_accum.sv
// Directed bench for sparam_iq_accum: default-size instance plus a 24-bit accumulator instance.
// Expected overflow results follow SPARAM_ACC_SAT_EN when it is defined for the build.
module tb_sparam_iq_accum;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start;
   logic [23:0] ftw;
   logic [15:0] n_samples;
   logic        s_valid;
   logic        s_ready;
   logic [11:0] s_data;
   logic        m_valid;
   logic        m_ready;
   logic [39:0] m_i;
   logic [39:0] m_q;
   logic        busy;
   logic        ovf;

   logic        start_b;
   logic [23:0] ftw_b;
   logic [15:0] n_b;
   logic        s_valid_b;
   logic        s_ready_b;
   logic [11:0] s_data_b;
   logic        m_valid_b;
   logic        m_ready_b;
   logic [23:0] m_i_b;
   logic [23:0] m_q_b;
   logic        busy_b;
   logic        ovf_b;

   sparam_iq_accum dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .ftw       (ftw),
      .n_samples (n_samples),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_i       (m_i),
      .m_q       (m_q),
      .busy      (busy),
      .ovf       (ovf)
   );

   sparam_iq_accum #(.AW(24)) dut24 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_b),
      .ftw       (ftw_b),
      .n_samples (n_b),
      .s_valid   (s_valid_b),
      .s_ready   (s_ready_b),
      .s_data    (s_data_b),
      .m_valid   (m_valid_b),
      .m_ready   (m_ready_b),
      .m_i       (m_i_b),
      .m_q       (m_q_b),
      .busy      (busy_b),
      .ovf       (ovf_b)
   );

   int checks   = 0;
   int failures = 0;

   localparam logic [39:0] S1_I = 40'd3275200;
   localparam logic [39:0] S2_V = 40'd16376000;
`ifdef SPARAM_ACC_SAT_EN
   localparam logic [23:0] S5_I = 24'h800000;
`else
   localparam logic [23:0] S5_I = 24'h401800;
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] pat(input int mode, input int k);
      logic [11:0] v;
      v = 12'd0;
      case (mode)
         0: v = 12'd100;
         1: if (k % 4 == 0) v = 12'd1000; else if (k % 4 == 2) v = -12'sd1000;
         2: if (k % 4 == 1) v = 12'd1000; else if (k % 4 == 3) v = -12'sd1000;
         default: v = 12'd0;
      endcase
      return v;
   endfunction

   task automatic check_idle_outputs(input string nm);
      check({nm, "_s_ready"}, 64'(s_ready), 64'd0);
      check({nm, "_m_valid"}, 64'(m_valid), 64'd0);
      check({nm, "_busy"},    64'(busy),    64'd0);
      check({nm, "_ovf"},     64'(ovf),     64'd0);
      check({nm, "_m_i"},     64'(m_i),     64'd0);
      check({nm, "_m_q"},     64'(m_q),     64'd0);
   endtask

   task automatic measure(input string nm, input logic [23:0] f, input int n, input int mode,
                          input bit rnd, input bit poke, input int hold,
                          input logic [39:0] exp_i, input logic [39:0] exp_q);
      int k;
      int cyc;
      bit acc;
      bit poked;
      k     = 0;
      cyc   = 0;
      poked = 1'b0;
      ftw       = f;
      n_samples = 16'(n);
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      // Inputs change after the start edge so the latched copies are what matter.
      ftw       = 24'h123456;
      n_samples = 16'd7;
      while (k < n && cyc < 1000) begin
         s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         s_data  = pat(mode, k);
         if (poke && k == 5 && !poked) begin
            start     = 1'b1;
            ftw       = 24'h400000;
            n_samples = 16'd3;
            poked     = 1'b1;
         end
         acc = s_valid && s_ready;
         @(posedge clk); #1;
         start = 1'b0;
         if (acc) k++;
         cyc++;
      end
      s_valid = 1'b0;
      check({nm, "_fed"}, 64'(k), 64'(n));
      cyc = 0;
      while (!m_valid && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      // Last sample accepted in cycle c; two DRAIN cycles; m_valid in cycle c+3.
      check({nm, "_latency"}, 64'(cyc), 64'd2);
      check({nm, "_m_valid"}, 64'(m_valid), 64'd1);
      check({nm, "_m_i"},     64'(m_i),     64'(exp_i));
      check({nm, "_m_q"},     64'(m_q),     64'(exp_q));
      check({nm, "_ovf"},     64'(ovf),     64'd0);
      check({nm, "_s_ready"}, 64'(s_ready), 64'd0);
      m_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check({nm, "_hold_valid"}, 64'(m_valid), 64'd1);
         check({nm, "_hold_i"},     64'(m_i),     64'(exp_i));
         check({nm, "_hold_q"},     64'(m_q),     64'(exp_q));
      end
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      check({nm, "_post_valid"}, 64'(m_valid), 64'd0);
      check({nm, "_post_busy"},  64'(busy),    64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int cyc;
      rst_n = 1'b0; start = 1'b0; ftw = '0; n_samples = '0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      start_b = 1'b0; ftw_b = '0; n_b = '0; s_valid_b = 1'b0; s_data_b = '0; m_ready_b = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      measure("s1", 24'h000000, 16, 0, 1'b0, 1'b0, 0, S1_I, 40'd0);
      measure("s2a", 24'h400000, 16, 1, 1'b0, 1'b0, 0, S2_V, 40'd0);
      measure("s2b", 24'h400000, 16, 2, 1'b0, 1'b0, 0, 40'd0, S2_V);
      measure("s3", 24'h000000, 16, 0, 1'b1, 1'b0, 20, S1_I, 40'd0);
      measure("s4_start_ignored", 24'h000000, 16, 0, 1'b0, 1'b1, 0, S1_I, 40'd0);

      // Abort with reset after five samples.
      ftw = 24'h0; n_samples = 16'd16; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      s_valid = 1'b1; s_data = 12'd100;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      s_valid = 1'b0;
      check_idle_outputs("s4_abort");
      repeat (6) @(posedge clk);
      #1;
      check("s4_abort_no_result", 64'(m_valid), 64'd0);
      check("s4_abort_idle",      64'(busy),    64'd0);
      measure("s4_fresh", 24'h000000, 16, 0, 1'b0, 1'b0, 0, S1_I, 40'd0);

      // Zero-length measurement.
      n_samples = 16'd0; ftw = 24'h0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("s6_m_valid", 64'(m_valid), 64'd1);
      check("s6_m_i",     64'(m_i),     64'd0);
      check("s6_m_q",     64'(m_q),     64'd0);
      check("s6_s_ready", 64'(s_ready), 64'd0);
      check("s6_ovf",     64'(ovf),     64'd0);
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      check("s6_post_valid", 64'(m_valid), 64'd0);
      check("s6_post_ready", 64'(s_ready), 64'd0);

      // Overflow on the 24-bit accumulator instance.
      ftw_b = 24'h0; n_b = 16'd3; start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      s_valid_b = 1'b1; s_data_b = 12'h800;
      k = 0; cyc = 0;
      while (k < 3 && cyc < 100) begin
         if (s_ready_b) k++;
         @(posedge clk); #1;
         cyc++;
      end
      s_valid_b = 1'b0;
      check("s5_fed", 64'(k), 64'd3);
      cyc = 0;
      while (!m_valid_b && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("s5_m_valid", 64'(m_valid_b), 64'd1);
      check("s5_m_i",     64'(m_i_b),     64'(S5_I));
      check("s5_m_q",     64'(m_q_b),     64'd0);
      check("s5_ovf",     64'(ovf_b),     64'd1);
      m_ready_b = 1'b1;
      @(posedge clk); #1;
      m_ready_b = 1'b0;
      check("s5_post_busy", 64'(busy_b), 64'd0);

      // ovf must clear on the next start.
      ftw_b = 24'h0; n_b = 16'd0; start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      check("s5_ovf_cleared", 64'(ovf_b), 64'd0);
      m_ready_b = 1'b1;
      @(posedge clk); #1;
      m_ready_b = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
